// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and occupancy encoding for the FIFO read adapter
// Purpose: buffer depth, occupancy width and the EMPTY/ONE/TWO occupancy states
//          used by fifo_stream_reader and its stream_buf2 storage.
// Ports:   none (package).
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_WIDTH = 2;

    typedef enum logic [OCC_WIDTH-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - two-entry output word buffer with head/tail pointers
// Purpose: holds up to two words between the FIFO read port and the output stream.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   clear_i      drop all held words (pointers and occupancy to 0)
//   push_i       write push_data_i into the tail entry
//   push_data_i  word to store
//   pop_i        retire the head entry
//   occ_o        number of held words (EMPTY/ONE/TWO)
//   head_data_o  word at the head entry
import fifo_rd_pkg::*;

module stream_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output occ_e                  occ_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    occ_e                  occ_q, occ_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i) begin
            occ_d  = EMPTY;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (push_i) tail_d = ~tail_q;
            if (pop_i)  head_d = ~head_q;
            // push and pop together leave the count alone
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_e'(occ_q + 2'd1);
                2'b01:   occ_d = occ_e'(occ_q - 2'd1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q  <= EMPTY;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[head_q];

    // the credit check upstream must never let a word arrive into a full buffer
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && occ_q == TWO));

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side adapter turning FIFO pops into a valid/ready stream
// Purpose: issues credit-limited pops, absorbs the FIFO's one-cycle read latency,
//          supports flush, and counts delivered beats.
// Ports:
//   rd_clk        FIFO read clock
//   reset         asynchronous active-high reset
//   fifo_rd_en    pop request to the FIFO
//   fifo_rd_data  FIFO read data, valid the cycle after a pop
//   fifo_empty    FIFO empty flag
//   flush         discard buffered and in-flight words
//   m_valid       output word available
//   m_ready       downstream accepts the word
//   m_data        output word
//   beat_count    completed output handshakes, wrapping
import fifo_rd_pkg::*;

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    logic                 inflight_q;
    logic                 discard_q;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    occ_e                 occ;
    logic                 pop_out;
    logic                 capture;
    logic [2:0]           credit;

    assign m_valid = (occ != EMPTY);
    assign pop_out = m_valid && m_ready;

    // words held plus the one on its way, minus the one leaving this cycle
    assign credit     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};
    assign fifo_rd_en = !reset && !fifo_empty && !flush && (credit < 3'd2);

    // a word arriving during a flush, or one requested just before it, is dropped
    assign capture = inflight_q && !discard_q && !flush;

    assign beat_d = pop_out ? beat_q + CNT_WIDTH'(1) : beat_q;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            discard_q  <= flush && inflight_q;
            beat_q     <= beat_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (rd_clk),
        .rst_i       (reset),
        .clear_i     (flush),
        .push_i      (capture),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop_out),
        .occ_o       (occ),
        .head_data_o (m_data)
    );

    assign beat_count = beat_q;

endmodule
